// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register byte offsets, vector type and byte-strobe helper shared by irq_ctrl
package irq_ctrl_pkg;
  localparam logic [4:0] IRQ_CTRL_ENABLE   = 5'h00;
  localparam logic [4:0] IRQ_CTRL_PENDING  = 5'h04;
  localparam logic [4:0] IRQ_CTRL_TYPE     = 5'h08;
  localparam logic [4:0] IRQ_CTRL_POLARITY = 5'h0C;
  localparam logic [4:0] IRQ_CTRL_STATUS   = 5'h10;
  localparam logic [4:0] IRQ_CTRL_SWTRIG   = 5'h14;
  typedef logic [31:0] irq_vec_t;
  function automatic irq_vec_t byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction
endpackage

// File: rtl/irq_sync.sv
// irq_sync: STAGES-deep multi-bit synchronizer; ports clk_i, rst_i (async high), d (async in), q (synchronized out)
module irq_sync #(
  parameter int W = 32,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] st;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) st <= '0;
    else st <= {st[STAGES-2:0], d};
  assign q = st[STAGES-1];
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller (sync, polarity, edge/level, pending, enable) with nmi-style register port; optional SWTRIG via IRQ_CTRL_SWTRIG_EN
// Ports: clk_i, rst_i (async high), irq_src_i (raw sources), mem_valid_i/mem_addr_i/mem_wdata_i/mem_wstrb_i (request),
//        mem_rdata_o/mem_ready_o (one-cycle completion), irq_o (registered PENDING & ENABLE)
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int IRQ_NUM = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic               mem_valid_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  input  logic [3:0]         mem_wstrb_i,
  output logic [31:0]        mem_rdata_o,
  output logic               mem_ready_o,
  output logic [IRQ_NUM-1:0] irq_o
);
  logic [IRQ_NUM-1:0] en, pend, typ, pol, prev, sync, s, rise, wm, wd, clr, sw, pend_n;
  logic [4:0] off;
  logic acc, wr;
  irq_vec_t wm_full, rd;
  logic unused;
  assign unused = ^{mem_addr_i[31:5], mem_addr_i[1:0]};
  irq_sync #(.W(IRQ_NUM), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d(irq_src_i),
    .q(sync)
  );
  always_comb begin
    off = {mem_addr_i[4:2], 2'b00};
    acc = mem_valid_i & ~mem_ready_o;
    wr = acc & (|mem_wstrb_i);
    wm_full = byte_mask(mem_wstrb_i);
    wm = wm_full[IRQ_NUM-1:0];
    wd = mem_wdata_i[IRQ_NUM-1:0] & wm;
    s = sync ^ pol;
    rise = s & ~prev;
    clr = (wr && off == IRQ_CTRL_PENDING) ? wd : '0;
`ifdef IRQ_CTRL_SWTRIG_EN
    sw = (wr && off == IRQ_CTRL_SWTRIG) ? wd : '0;
`else
    sw = '0;
`endif
    // set terms are OR-ed after the clear, so an edge coinciding with W1C survives
    pend_n = (typ & ((pend & ~clr) | rise | sw)) | (~typ & s);
    rd = off == IRQ_CTRL_ENABLE   ? irq_vec_t'(en) :
         off == IRQ_CTRL_PENDING  ? irq_vec_t'(pend) :
         off == IRQ_CTRL_TYPE     ? irq_vec_t'(typ) :
         off == IRQ_CTRL_POLARITY ? irq_vec_t'(pol) :
         off == IRQ_CTRL_STATUS   ? irq_vec_t'(pend & en) : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      en <= '0;
      pend <= '0;
      typ <= '0;
      pol <= '0;
      prev <= '0;
      irq_o <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      prev <= s;
      pend <= pend_n;
      irq_o <= pend & en;
      mem_ready_o <= acc;
      mem_rdata_o <= acc ? rd : '0;
      if (wr && off == IRQ_CTRL_ENABLE) en <= (en & ~wm) | wd;
      if (wr && off == IRQ_CTRL_TYPE) typ <= (typ & ~wm) | wd;
      if (wr && off == IRQ_CTRL_POLARITY) pol <= (pol & ~wm) | wd;
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan steps plus randomized traffic checked against a behavioural model
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;
  localparam int N = 32;
  localparam int STG = 2;
  logic clk = 0, rst = 1, valid = 0, ready;
  logic [N-1:0] src = '0, irq;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  irq_ctrl #(.IRQ_NUM(N), .SYNC_STAGES(STG)) dut (
    .clk_i(clk), .rst_i(rst), .irq_src_i(src), .mem_valid_i(valid), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_wstrb_i(wstrb), .mem_rdata_o(rdata), .mem_ready_o(ready), .irq_o(irq)
  );
  logic [31:0] m_en, m_pend, m_type, m_pol, m_irq, m_prev;
  logic [31:0] samp[$];
  function automatic void m_reset();
    m_en = 0; m_pend = 0; m_type = 0; m_pol = 0; m_irq = 0; m_prev = 0;
    samp = {};
    for (int i = 0; i < STG; i++) samp.push_back(32'd0);
  endfunction
  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] off);
    case (off)
      IRQ_CTRL_ENABLE:   return m_en;
      IRQ_CTRL_PENDING:  return m_pend;
      IRQ_CTRL_TYPE:     return m_type;
      IRQ_CTRL_POLARITY: return m_pol;
      IRQ_CTRL_STATUS:   return m_pend & m_en;
      default:           return 32'd0;
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // one clock edge: advance the model by the line rules, then compare irq
  task automatic step(input bit acc);
    logic [31:0] s, ev, wm, wd, clr, sw;
    logic [4:0] off;
    bit w;
    @(posedge clk);
    s = samp[0] ^ m_pol;
    ev = s & ~m_prev;
    w = acc && wstrb != 0;
    off = {addr[4:2], 2'b00};
    wm = bmask(wstrb);
    wd = wdata & wm;
    clr = (w && off == IRQ_CTRL_PENDING) ? wd : 32'd0;
`ifdef IRQ_CTRL_SWTRIG_EN
    sw = (w && off == IRQ_CTRL_SWTRIG) ? wd : 32'd0;
`else
    sw = 32'd0;
`endif
    m_irq = m_pend & m_en;
    for (int i = 0; i < N; i++)
      if (m_type[i]) m_pend[i] = (m_pend[i] && !clr[i]) || ev[i] || sw[i];
      else m_pend[i] = s[i];
    if (w && off == IRQ_CTRL_ENABLE) m_en = (m_en & ~wm) | wd;
    if (w && off == IRQ_CTRL_TYPE) m_type = (m_type & ~wm) | wd;
    if (w && off == IRQ_CTRL_POLARITY) m_pol = (m_pol & ~wm) | wd;
    m_prev = s;
    samp.push_back(src);
    void'(samp.pop_front());
    #1;
    check("irq", irq, m_irq);
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st, output logic [31:0] rd);
    logic [31:0] exp;
    valid = 1; addr = a; wdata = d; wstrb = st;
    exp = m_read({a[4:2], 2'b00});
    step(1);
    check("ready_hi", {31'd0, ready}, 32'd1);
    if (st == 0) check($sformatf("rd%02h", a[7:0]), rdata, exp);
    rd = rdata;
    valid = 0; wstrb = 0;
    step(0);
    check("ready_lo", {31'd0, ready}, 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask
  task automatic rdr(input logic [31:0] a, output logic [31:0] r);
    bus(a, 32'd0, 4'h0, r);
  endtask
  initial begin
    logic [31:0] r;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_irq", irq, 32'd0);
    for (int i = 0; i < 8; i++) rdr(32'(i * 4), r);
    // level line 5
    wr(IRQ_CTRL_TYPE, 32'h0);
    wr(IRQ_CTRL_ENABLE, 32'h20);
    src[5] = 1;
    repeat (3) step(0);
    check("lvl_early", {31'd0, irq[5]}, 32'd0);
    step(0);
    check("lvl_irq", {31'd0, irq[5]}, 32'd1);
    rdr(IRQ_CTRL_STATUS, r);
    check("lvl_status", r, 32'h20);
    src[5] = 0;
    repeat (3) step(0);
    check("lvl_hold", {31'd0, irq[5]}, 32'd1);
    step(0);
    check("lvl_rel", {31'd0, irq[5]}, 32'd0);
    // edge line 6 with W1C
    wr(IRQ_CTRL_TYPE, 32'h40);
    wr(IRQ_CTRL_ENABLE, 32'h40);
    src[6] = 1;
    repeat (3) step(0);
    src[6] = 0;
    repeat (4) step(0);
    rdr(IRQ_CTRL_PENDING, r);
    check("edge_pend", r, 32'h40);
    check("edge_irq", {31'd0, irq[6]}, 32'd1);
    wr(IRQ_CTRL_PENDING, 32'h40);
    check("w1c_irq", {31'd0, irq[6]}, 32'd0);
    // masking
    wr(IRQ_CTRL_ENABLE, 32'h0);
    src[6] = 1;
    repeat (3) step(0);
    src[6] = 0;
    repeat (4) step(0);
    check("mask_irq", irq, 32'd0);
    rdr(IRQ_CTRL_PENDING, r);
    check("mask_pend", r, 32'h40);
    wr(IRQ_CTRL_ENABLE, 32'h40);
    check("unmask_irq", {31'd0, irq[6]}, 32'd1);
    wr(IRQ_CTRL_PENDING, 32'h40);
    // polarity on line 8
    src[8] = 1;
    repeat (4) step(0);
    wr(IRQ_CTRL_POLARITY, 32'h100);
    repeat (4) step(0);
    wr(IRQ_CTRL_TYPE, 32'h140);
    wr(IRQ_CTRL_ENABLE, 32'h140);
    rdr(IRQ_CTRL_PENDING, r);
    check("pol_nopend", r, 32'h0);
    src[8] = 0;
    repeat (4) step(0);
    rdr(IRQ_CTRL_PENDING, r);
    check("pol_pend", r, 32'h100);
    wr(IRQ_CTRL_PENDING, 32'h100);
    wr(IRQ_CTRL_POLARITY, 32'h0);
    // collision: edge set lands on the W1C accept edge
    src[6] = 1;
    repeat (3) step(0);
    src[6] = 0;
    repeat (4) step(0);
    src[6] = 1;
    repeat (STG) step(0);
    wr(IRQ_CTRL_PENDING, 32'h40);
    rdr(IRQ_CTRL_PENDING, r);
    check("coll_pend", {31'd0, r[6]}, 32'd1);
    src[6] = 0;
    rdr(32'h18, r);
    check("unmap18", r, 32'd0);
    rdr(32'h1C, r);
    check("unmap1c", r, 32'd0);
    // software trigger
    wr(IRQ_CTRL_PENDING, 32'h40);
    wr(IRQ_CTRL_SWTRIG, 32'h40);
    rdr(IRQ_CTRL_PENDING, r);
`ifdef IRQ_CTRL_SWTRIG_EN
    check("swtrig_pend", {31'd0, r[6]}, 32'd1);
`else
    check("swtrig_pend", {31'd0, r[6]}, 32'd0);
`endif
    rdr(IRQ_CTRL_SWTRIG, r);
    check("swtrig_rd", r, 32'd0);
    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      src ^= $urandom & $urandom & $urandom;
      if ($urandom_range(0, 1) == 0) step(0);
      else bus({27'd0, 3'($urandom_range(0, 7)), 2'b00}, $urandom,
               ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), r);
    end
    // reset while a write is outstanding
    wr(IRQ_CTRL_ENABLE, 32'hFFFF_FFFF);
    src = '0;
    valid = 1; addr = 32'(IRQ_CTRL_ENABLE); wdata = 32'h1234_5678; wstrb = 4'hF;
    #2 rst = 1;
    m_reset();
    @(posedge clk);
    #1 check("rstmid_ready", {31'd0, ready}, 32'd0);
    valid = 0; wstrb = 0;
    @(posedge clk);
    #1 check("rstmid_irq", irq, 32'd0);
    rst = 0;
    check("rstmid_ready2", {31'd0, ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rdr(32'(i * 4), r);
      check($sformatf("rstmid_reg%0d", i), r, 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller sitting directly upstream of core_wrapper's 32-bit irq_i vector.
- Replaces the raw wiring of the external pin and peripheral interrupt lines.
- Synchronizes each source and applies per-line polarity and edge/level selection.
- Latches edge events into pending bits, masks them with an enable register and drives a registered irq vector to the core.
- Register-programmed over a native memory (nmi-style) slave port decoded by bus.

Parameters:
- IRQ_NUM, 32: number of interrupt lines; legal range 1..32. Unused bits of the 32-bit registers read 0.
- SYNC_STAGES, 2: flop stages per source synchronizer; minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- irq_src_i  in  IRQ_NUM  raw interrupt sources; may be asynchronous to clk_i
- mem_valid_i  in  1  slave request valid; held high until mem_ready_o
- mem_addr_i  in  32  byte address; only bits [4:2] are decoded
- mem_wdata_i  in  32  write data
- mem_wstrb_i  in  4  byte strobes; all zero means read
- mem_rdata_o  out  32  read data, valid while mem_ready_o is high
- mem_ready_o  out  1  one-cycle completion pulse
- irq_o  out  IRQ_NUM  masked interrupt vector to the core

Behaviour:
- Reset: all registers, synchronizer flops, previous-value flops, irq_o, mem_ready_o and mem_rdata_o go to 0 asynchronously on rst_i.
- Register map:
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: read; write-1-to-clear.
  - 0x08 TYPE: RW; 1 = edge, 0 = level.
  - 0x0C POLARITY: RW; 1 = active-low.
  - 0x10 STATUS: RO; equals PENDING & ENABLE.
  - 0x14 SWTRIG: optional, see below.
  - Unmapped offsets read 0; writes to them are ignored.
- Byte strobes apply to every RW register and to the PENDING clear mask.
- Handshake:
  - A request is accepted when mem_valid_i=1 and mem_ready_o=0.
  - The write takes effect on the same edge that raises mem_ready_o.
  - mem_ready_o is high for exactly one cycle, so there is 1 wait state.
  - Back-to-back requests complete on every other cycle.
- Per-line datapath:
  - s = sync(irq_src_i) XOR POLARITY.
  - prev is a register holding the previous value of s.
  - Edge line: a rising edge is s & ~prev. It sets PENDING.
  - Level line: PENDING is loaded with s every cycle, and W1C has no lasting effect on it.
- Simultaneous edge set and W1C clear on the same bit in the same cycle: the set wins.
- irq_o = registered (PENDING & ENABLE).
- Latency: a source transition reaches irq_o SYNC_STAGES+2 clock edges after the first edge that samples the new level. For the default this is 4.
- Changing POLARITY while the source is static can create an edge in s. On an edge line this sets PENDING intentionally; software clears it.
- Changing TYPE from level to edge leaves PENDING at its current value.
- Pulses shorter than one clock period may be missed; this is not guaranteed.
- Reset asserted mid-transaction: the transaction is dropped and no mem_ready_o is issued for it.

Optional Feature:
- Macro: IRQ_CTRL_SWTRIG_EN.
- Defined: offset 0x14 SWTRIG is write-1-to-set on PENDING for edge lines and reads 0.
  - Writes to level-line bits are ignored.
  - SWTRIG set and W1C clear in the same cycle cannot occur, since only one bus access completes per cycle.
- Undefined: 0x14 is unmapped, so it reads 0 and writes are ignored.

Decomposition:
- Package irq_ctrl_pkg:
  - Register offset localparams IRQ_CTRL_ENABLE, IRQ_CTRL_PENDING, IRQ_CTRL_TYPE, IRQ_CTRL_POLARITY, IRQ_CTRL_STATUS and IRQ_CTRL_SWTRIG.
  - Typedef irq_vec_t, 32 bits.
- Sub-module irq_sync: a parameterized SYNC_STAGES multi-bit synchronizer with asynchronous active-high reset, instantiated once for the full vector.

Test Plan:
- Level line: reset, write TYPE=0x0, ENABLE=0x20, then drive irq_src_i[5]=1. Expect irq_o[5]=1 after 4 clocks and STATUS=0x20. Release the source: irq_o[5]=0 after 4 clocks.
- Edge with W1C: write TYPE=0x40, ENABLE=0x40, then pulse irq_src_i[6] high for 3 clocks. Expect PENDING=0x40 held after the pulse ends. Write 0x40 to PENDING: irq_o[6]=0 two cycles later.
- Masking: with the line-6 edge pending and ENABLE=0, irq_o=0 and PENDING reads 0x40. Write ENABLE=0x40: irq_o[6]=1 on the cycle after the write completes.
- Polarity: with TYPE=0x100 and ENABLE=0x100, set POLARITY=0x100 while irq_src_i[8]=1. Expect no pending. Drive irq_src_i[8]=0: PENDING[8]=1.
- Collision: align an irq_src_i[6] edge with a W1C write to bit 6 on the same clock. PENDING[6] reads 1 afterwards. Also check unmapped 0x18 reads 0 and mem_ready_o is high for exactly 1 cycle per access.
- Reset mid-access: assert rst_i in the cycle after mem_valid_i rises. Expect mem_ready_o=0, all registers 0 and irq_o=0. With IRQ_CTRL_SWTRIG_EN, writing 0x14=0x40 on an edge line gives PENDING=0x40.
